stm_gain_reader: RTL and testbench

Read-side consumer of the STM gain memory port: on an update strobe it sweeps every transducer address of one gain pattern (index, segment) and turns the memory's 64-bit, 4-lane words into a serial stream of per-transducer intensity/phase pairs. It sits between the STM controller (which picks pattern index and segment) and the downstream per-transducer pipeline (filter / duty-table lookup). It drives `GAIN_IDX`, `GAIN_ADDR` and `SEGMENT` into `memory` and consumes `VALUE` at that port's fixed 2-cycle read latency.

---
 rtl/stm_gain_reader_pkg.sv | 38 +++
 rtl/stm_gain_reader_unpack.sv | 5 +
 rtl/stm_gain_unpack.sv | 54 +++++
 rtl/stm_gain_reader.sv | 90 +++++++++
 tb/tb_stm_gain_reader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stm_gain_reader_pkg.sv
// Shared types and constants for the STM gain pattern reader.
// Pattern geometry, FSM state encoding and the lane extraction helper.
package stm_gain_reader_pkg;

  localparam int GAIN_DEPTH  = 249;
  localparam int GAIN_LANE_W = 16;
  localparam int GAIN_LANES  = 4;

  localparam logic [1:0] STM_MODE_GAIN = 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } stm_gain_reader_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] addr;
  } gain_tag_t;

  function automatic logic [GAIN_LANE_W-1:0] gain_lane(
    input logic [63:0] word,
    input logic [1:0]  lane
  );
    logic [GAIN_LANE_W-1:0] r;
    r = '0;
    unique case (lane)
      2'd0: r = word[15:0];
      2'd1: r = word[31:16];
      2'd2: r = word[47:32];
      2'd3: r = word[63:48];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stm_gain_reader_unpack.sv
// Tag pipeline depth constant for the gain reader unpack stage.
// The unpack logic itself is in stm_gain_unpack.sv.
package stm_gain_reader_unpack_pkg;
  localparam int TAG_STAGES = 2;
endpackage

// File: rtl/stm_gain_unpack.sv
// Tag pipeline aligned to the 2-cycle memory latency, lane select
// and the registered intensity/phase output stage.
module stm_gain_unpack
  import stm_gain_reader_pkg::*;
#(
  parameter int DEPTH = GAIN_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ISSUE_VALID,
  input  logic [7:0]  ISSUE_ADDR,
  input  logic [63:0] VALUE,
  output logic [7:0]  INTENSITY,
  output logic [7:0]  PHASE,
  output logic        DOUT_VALID,
  output logic [7:0]  DOUT_ADDR,
  output logic        DONE
);

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  gain_tag_t tag0;
  gain_tag_t tag1;
  logic [GAIN_LANE_W-1:0] lane_q;

  // tag1 lines up with VALUE for the address it carries
  always_comb begin
    lane_q = gain_lane(VALUE, tag1.addr[1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag0       <= '0;
      tag1       <= '0;
      INTENSITY  <= '0;
      PHASE      <= '0;
      DOUT_VALID <= 1'b0;
      DOUT_ADDR  <= '0;
      DONE       <= 1'b0;
    end else begin
      tag0.valid <= ISSUE_VALID;
      tag0.addr  <= ISSUE_ADDR;
      tag1       <= tag0;
      DOUT_VALID <= tag1.valid;
      DONE       <= tag1.valid && (tag1.addr == LAST);
      if (tag1.valid) begin
        DOUT_ADDR <= tag1.addr;
        INTENSITY <= lane_q[15:8];
        PHASE     <= lane_q[7:0];
      end
    end
  end

endmodule

// File: rtl/stm_gain_reader.sv
// Sweeps all transducer addresses of one gain pattern and streams
// per-transducer intensity/phase from the 4-lane gain memory words.
module stm_gain_reader
  import stm_gain_reader_pkg::*;
#(
  parameter int DEPTH = GAIN_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        UPDATE,
  input  logic [9:0]  IDX_IN,
  input  logic        SEGMENT_IN,
  output logic [9:0]  GAIN_IDX,
  output logic [7:0]  GAIN_ADDR,
  output logic        SEGMENT,
  input  logic [63:0] VALUE,
  output logic [7:0]  INTENSITY,
  output logic [7:0]  PHASE,
  output logic        DOUT_VALID,
  output logic [7:0]  DOUT_ADDR,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [7:0] LAST = 8'(DEPTH - 1);

  stm_gain_reader_state_t state;
  stm_gain_reader_state_t state_nxt;

  logic start;
  logic issue_valid;

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    issue_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (UPDATE) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (GAIN_ADDR == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (DONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      GAIN_IDX  <= '0;
      GAIN_ADDR <= '0;
      SEGMENT   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        GAIN_IDX  <= IDX_IN;
        SEGMENT   <= SEGMENT_IN;
        GAIN_ADDR <= '0;
      end else if (issue_valid && GAIN_ADDR != LAST) begin
        GAIN_ADDR <= GAIN_ADDR + 8'd1;
      end
    end
  end

  assign BUSY = (state != IDLE);

  stm_gain_unpack #(
    .DEPTH(DEPTH)
  ) u_unpack (
    .CLK        (CLK),
    .RST        (RST),
    .ISSUE_VALID(issue_valid),
    .ISSUE_ADDR (GAIN_ADDR),
    .VALUE      (VALUE),
    .INTENSITY  (INTENSITY),
    .PHASE      (PHASE),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_ADDR  (DOUT_ADDR),
    .DONE       (DONE)
  );

endmodule

// File: tb/tb_stm_gain_reader.sv
// Directed bench for stm_gain_reader with a 2-cycle gain memory model
// and a DEPTH=5 instance fed hand-written words.
module tb_stm_gain_reader;

  localparam int D = 249;

  logic        CLK = 1'b0;
  logic        RST;
  logic        UPDATE;
  logic [9:0]  IDX_IN;
  logic        SEGMENT_IN;
  logic [9:0]  GAIN_IDX;
  logic [7:0]  GAIN_ADDR;
  logic        SEGMENT;
  logic [63:0] VALUE;
  logic [7:0]  INTENSITY;
  logic [7:0]  PHASE;
  logic        DOUT_VALID;
  logic [7:0]  DOUT_ADDR;
  logic        BUSY;
  logic        DONE;

  logic        s_update;
  logic [9:0]  s_gidx;
  logic [7:0]  s_gaddr;
  logic        s_seg;
  logic [63:0] s_value;
  logic [7:0]  s_int;
  logic [7:0]  s_ph;
  logic        s_valid;
  logic [7:0]  s_daddr;
  logic        s_busy;
  logic        s_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  stm_gain_reader #(.DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .UPDATE(UPDATE),
    .IDX_IN(IDX_IN), .SEGMENT_IN(SEGMENT_IN),
    .GAIN_IDX(GAIN_IDX), .GAIN_ADDR(GAIN_ADDR),
    .SEGMENT(SEGMENT), .VALUE(VALUE),
    .INTENSITY(INTENSITY), .PHASE(PHASE),
    .DOUT_VALID(DOUT_VALID), .DOUT_ADDR(DOUT_ADDR),
    .BUSY(BUSY), .DONE(DONE)
  );

  stm_gain_reader #(.DEPTH(5)) dut_s (
    .CLK(CLK), .RST(RST), .UPDATE(s_update),
    .IDX_IN(10'd7), .SEGMENT_IN(1'b1),
    .GAIN_IDX(s_gidx), .GAIN_ADDR(s_gaddr),
    .SEGMENT(s_seg), .VALUE(s_value),
    .INTENSITY(s_int), .PHASE(s_ph),
    .DOUT_VALID(s_valid), .DOUT_ADDR(s_daddr),
    .BUSY(s_busy), .DONE(s_done)
  );

  function automatic logic [15:0] lane_data(
    input logic seg, input logic [9:0] idx, input logic [7:0] a
  );
    logic [7:0] i;
    logic [7:0] p;
    i = idx[7:0] * 8'd7 + a * 8'd3 + (seg ? 8'd91 : 8'd0);
    p = (a * 8'd13) ^ idx[7:0] ^ {idx[9:8], 5'b0, seg};
    return {i, p};
  endfunction

  function automatic logic [63:0] word_of(
    input logic seg, input logic [9:0] idx, input logic [5:0] wa
  );
    logic [63:0] w;
    for (int l = 0; l < 4; l++)
      w[16*l +: 16] = lane_data(seg, idx, {wa, 2'(l)});
    return w;
  endfunction

  logic [63:0] mem_r1;
  always @(posedge CLK) begin
    mem_r1 <= word_of(SEGMENT, GAIN_IDX, GAIN_ADDR[7:2]);
    VALUE  <= mem_r1;
  end

  localparam logic [63:0] W0 = 64'h1144_1033_1022_1011;
  localparam logic [63:0] W1 = 64'h2244_2033_2022_20AA;
  logic [63:0] s_r1;
  always @(posedge CLK) begin
    s_r1    <= (s_gaddr[7:2] == 6'd0) ? W0 :
               (s_gaddr[7:2] == 6'd1) ? W1 : 64'd0;
    s_value <= s_r1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({GAIN_IDX, GAIN_ADDR, SEGMENT} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_mem got %h want 0", {GAIN_IDX, GAIN_ADDR, SEGMENT});
    end
    n_cmp++;
    if ({INTENSITY, PHASE, DOUT_ADDR} !== 24'd0) begin
      n_err++;
      $display("FAIL reset_data got %h want 0", {INTENSITY, PHASE, DOUT_ADDR});
    end
    n_cmp++;
    if ({DOUT_VALID, BUSY, DONE} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000", {DOUT_VALID, BUSY, DONE});
    end
    n_cmp++;
    if ({s_valid, s_busy, s_done, s_daddr} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_small got %h want 0", {s_valid, s_busy, s_done, s_daddr});
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_sweep(
    input logic [9:0] idx, input logic seg,
    input int pa, input int pb, input string nm
  );
    logic [7:0]  ea;
    logic [15:0] ed;
    logic [7:0]  egaddr;
    UPDATE = 1'b1;
    IDX_IN = idx;
    SEGMENT_IN = seg;
    tick();
    UPDATE = 1'b0;
    for (int c = 1; c <= D + 4; c++) begin
      n_cmp++;
      if (BUSY !== (c <= D + 3)) begin
        n_err++;
        $display("FAIL %s busy c%0d got %b want %b", nm, c, BUSY, c <= D + 3);
      end
      n_cmp++;
      if (DONE !== (c == D + 3)) begin
        n_err++;
        $display("FAIL %s done c%0d got %b want %b", nm, c, DONE, c == D + 3);
      end
      n_cmp++;
      if (DOUT_VALID !== (c >= 4 && c <= D + 3)) begin
        n_err++;
        $display("FAIL %s valid c%0d got %b", nm, c, DOUT_VALID);
      end
      n_cmp++;
      if (GAIN_IDX !== idx || SEGMENT !== seg) begin
        n_err++;
        $display("FAIL %s gidx c%0d got %0d/%b want %0d/%b",
                 nm, c, GAIN_IDX, SEGMENT, idx, seg);
      end
      egaddr = (c <= D) ? 8'(c - 1) : 8'(D - 1);
      n_cmp++;
      if (GAIN_ADDR !== egaddr) begin
        n_err++;
        $display("FAIL %s gaddr c%0d got %0d want %0d", nm, c, GAIN_ADDR, egaddr);
      end
      if (c >= 4) begin
        ea = (c <= D + 3) ? 8'(c - 4) : 8'(D - 1);
        ed = lane_data(seg, idx, ea);
        n_cmp++;
        if (DOUT_ADDR !== ea || {INTENSITY, PHASE} !== ed) begin
          n_err++;
          $display("FAIL %s out c%0d got a%0d %h want a%0d %h",
                   nm, c, DOUT_ADDR, {INTENSITY, PHASE}, ea, ed);
        end
      end
      UPDATE = (c == pa || c == pb);
      IDX_IN = 10'h2AA;
      SEGMENT_IN = ~seg;
      if (c < D + 4) tick();
    end
    UPDATE = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    UPDATE = 1'b1;
    IDX_IN = 10'd3;
    SEGMENT_IN = 1'b0;
    tick();
    UPDATE = 1'b0;
    k = 0;
    while (!(DOUT_VALID && DOUT_ADDR == 8'd100) && k < 300) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 300) begin
      n_err++;
      $display("FAIL rst_mid timeout got addr %0d want 100", DOUT_ADDR);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++;
    if ({GAIN_IDX, GAIN_ADDR, SEGMENT, INTENSITY, PHASE, DOUT_ADDR} !== 43'd0) begin
      n_err++;
      $display("FAIL rst_mid outs got %h want 0",
               {GAIN_IDX, GAIN_ADDR, SEGMENT, INTENSITY, PHASE, DOUT_ADDR});
    end
    n_cmp++;
    if ({DOUT_VALID, BUSY, DONE} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid flags got %b want 000", {DOUT_VALID, BUSY, DONE});
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if ({DOUT_VALID, BUSY, DONE} !== 3'b000) begin
        n_err++;
        $display("FAIL rst_mid quiet c%0d got %b want 000", c, {DOUT_VALID, BUSY, DONE});
      end
    end
    test_sweep(10'd5, 1'b0, 0, 0, "after_rst");
  endtask

  task automatic test_back_to_back();
    test_sweep(10'd200, 1'b1, 0, 0, "b2b_a");
    test_sweep(10'd9, 1'b0, 0, 0, "b2b_b");
  endtask

  task automatic test_lane_small();
    logic [7:0] ei [5];
    logic [7:0] ep [5];
    ei = '{8'h10, 8'h10, 8'h10, 8'h11, 8'h20};
    ep = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    s_update = 1'b1;
    tick();
    s_update = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      n_cmp++;
      if (s_valid !== (c >= 4 && c <= 8) || s_done !== (c == 8)
          || s_busy !== (c <= 8)) begin
        n_err++;
        $display("FAIL small flags c%0d got v%b d%b b%b", c, s_valid, s_done, s_busy);
      end
      if (c >= 4 && c <= 8) begin
        n_cmp++;
        if (s_daddr !== 8'(c - 4) || s_int !== ei[c-4] || s_ph !== ep[c-4]) begin
          n_err++;
          $display("FAIL small lane c%0d got a%0d %h%h want a%0d %h%h",
                   c, s_daddr, s_int, s_ph, c - 4, ei[c-4], ep[c-4]);
        end
      end
      tick();
    end
  endtask

  initial begin
    RST = 1'b1;
    UPDATE = 1'b0;
    IDX_IN = '0;
    SEGMENT_IN = 1'b0;
    s_update = 1'b0;
    test_reset();
    test_sweep(10'd0, 1'b0, 0, 0, "idx0");
    repeat (3) tick();
    test_sweep(10'd1023, 1'b1, 0, 0, "idx1023");
    repeat (3) tick();
    test_sweep(10'd77, 1'b0, 10, 252, "ignore");
    repeat (3) tick();
    test_reset_mid();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_lane_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
